// File: rtl/beta_exe_wb_stage.sv
// Execute-to-writeback stage: a 2-entry result buffer between the ALU and the
// register-file write port, with SLT status conversion and youngest-first forwarding.

typedef struct packed {
  logic zero;
  logic overflow;
  logic negative;
} exe_alu_status_t;

module beta_exe_wb_stage #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    exe_valid_i,
  output logic                    exe_ready_o,
  input  logic [DataWidth-1:0]    exe_result_i,
  input  exe_alu_status_t         exe_stat_i,
  input  logic                    exe_slt_i,
  input  logic [RegAddrWidth-1:0] exe_rd_addr_i,
  input  logic                    exe_rd_we_i,
  input  logic                    flush_i,
  input  logic                    rf_grant_i,
  output logic                    rf_we_o,
  output logic [RegAddrWidth-1:0] rf_waddr_o,
  output logic [DataWidth-1:0]    rf_wdata_o,
  input  logic [RegAddrWidth-1:0] fwd_raddr_i,
  output logic                    fwd_hit_o,
  output logic [DataWidth-1:0]    fwd_data_o,
  output logic [1:0]              occupancy_o
);

  logic [DataWidth-1:0]    r_data [2];
  logic [RegAddrWidth-1:0] r_addr [2];
  logic [1:0]              r_we;
  logic [1:0]              r_vld;
  logic                    r_head;
  logic                    r_tail;
  logic [1:0]              r_count;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_nonempty;
  logic                    w_young;
  logic [DataWidth-1:0]    w_push_data;
  logic                    w_push_we;
  logic                    w_unused_stat;

  assign w_unused_stat = ^{exe_stat_i.zero, exe_stat_i.overflow};

  assign w_nonempty  = (r_count != 2'd0);
  assign exe_ready_o = rstn_i & (r_count != 2'd2) & ~flush_i;
  assign w_push      = exe_valid_i & exe_ready_o;

  assign w_push_data = exe_slt_i ? {{(DataWidth-1){1'b0}}, exe_stat_i.negative} : exe_result_i;
  assign w_push_we   = exe_rd_we_i & (exe_rd_addr_i != '0);

  // Head presentation; gated by reset so nothing is requested while it is held
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (rstn_i && w_nonempty) begin
      rf_we_o    = r_we[r_head] & ~flush_i;
      rf_waddr_o = r_addr[r_head];
      rf_wdata_o = r_data[r_head];
    end
  end

  // Non-writing entries retire without waiting for the arbiter
  assign w_pop = (rf_we_o & rf_grant_i) | (rstn_i & w_nonempty & ~r_we[r_head] & ~flush_i);

  assign occupancy_o = r_count;
  assign w_young     = ~r_tail;

  // Youngest entry (tail-1) is checked first; the other slot is the older one
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    if (rstn_i && fwd_raddr_i != '0) begin
      if (r_vld[w_young] && r_we[w_young] && r_addr[w_young] == fwd_raddr_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = r_data[w_young];
      end else if (r_vld[r_tail] && r_we[r_tail] && r_addr[r_tail] == fwd_raddr_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = r_data[r_tail];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_vld   <= 2'b00;
    end else if (flush_i) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_vld   <= 2'b00;
    end else begin
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload carries no reset; validity is tracked by r_vld/r_count
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_tail] <= w_push_data;
      r_addr[r_tail] <= exe_rd_addr_i;
      r_we[r_tail]   <= w_push_we;
    end
  end

endmodule

// File: tb/tb_beta_exe_wb_stage.sv
// Directed self-checking bench for beta_exe_wb_stage.

module tb_beta_exe_wb_stage;

  logic        clk;
  logic        rstn;
  logic        exe_valid;
  logic        exe_ready;
  logic [31:0] exe_result;
  logic [2:0]  exe_stat;
  logic        exe_slt;
  logic [4:0]  exe_rd_addr;
  logic        exe_rd_we;
  logic        flush;
  logic        rf_grant;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  beta_exe_wb_stage #(.DataWidth(32), .RegAddrWidth(5)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .exe_valid_i(exe_valid), .exe_ready_o(exe_ready),
    .exe_result_i(exe_result), .exe_stat_i(exe_stat), .exe_slt_i(exe_slt),
    .exe_rd_addr_i(exe_rd_addr), .exe_rd_we_i(exe_rd_we),
    .flush_i(flush), .rf_grant_i(rf_grant),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .fwd_raddr_i(fwd_raddr), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .occupancy_o(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic offer(input logic [4:0] rd, input logic [31:0] res);
    exe_valid   = 1'b1;
    exe_rd_addr = rd;
    exe_result  = res;
    exe_rd_we   = 1'b1;
    exe_slt     = 1'b0;
    exe_stat    = 3'b000;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; exe_valid = 0; exe_result = 0; exe_stat = 0; exe_slt = 0;
    exe_rd_addr = 0; exe_rd_we = 0; flush = 0; rf_grant = 0; fwd_raddr = 0;
    step();
    checks++; if (exe_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", exe_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", fwd_hit); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    rf_grant = 1'b1;
    offer(5'd5, 32'h7);
    #1;
    checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", exe_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_noflow got=%b exp=0", rf_we); end
    step();
    exe_valid = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_addr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'h7) begin errors++; $display("FAIL single_data got=%h exp=7", rf_wdata); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL single_occ0 got=%0d exp=0", occupancy); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we0 got=%b exp=0", rf_we); end
  endtask

  task automatic test_slt();
    rf_grant = 1'b0;
    offer(5'd3, 32'hFFFF_FFFE);
    exe_slt = 1'b1; exe_stat = 3'b001;
    step();
    exe_valid = 1'b0;
    #1;
    checks++; if (rf_wdata !== 32'h1) begin errors++; $display("FAIL slt_neg1 got=%h exp=00000001", rf_wdata); end
    checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL slt_addr got=%0d exp=3", rf_waddr); end
    rf_grant = 1'b1;
    step();
    offer(5'd3, 32'hFFFF_FFFE);
    exe_slt = 1'b1; exe_stat = 3'b110;
    rf_grant = 1'b0;
    step();
    exe_valid = 1'b0;
    #1;
    checks++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL slt_neg0 got=%h exp=00000000", rf_wdata); end
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL slt_we got=%b exp=1", rf_we); end
    rf_grant = 1'b1;
    step();
  endtask

  task automatic test_full();
    rf_grant = 1'b0;
    offer(5'd1, 32'hA);
    step();
    offer(5'd2, 32'hB);
    step();
    offer(5'd6, 32'hC);
    #1;
    checks++; if (exe_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", exe_ready); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL full_occ got=%0d exp=2", occupancy); end
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL full_stall got=%0d exp=2", occupancy); end
    rf_grant = 1'b1;
    #1;
    checks++; if (rf_waddr !== 5'd1 || rf_wdata !== 32'hA || rf_we !== 1'b1)
      begin errors++; $display("FAIL full_first got=%0d/%h/%b exp=1/0000000a/1", rf_waddr, rf_wdata, rf_we); end
    checks++; if (exe_ready !== 1'b0) begin errors++; $display("FAIL full_nobypass got=%b exp=0", exe_ready); end
    step();
    exe_valid = 1'b0;
    #1;
    checks++; if (exe_ready !== 1'b1) begin errors++; $display("FAIL full_reready got=%b exp=1", exe_ready); end
    checks++; if (rf_waddr !== 5'd2 || rf_wdata !== 32'hB)
      begin errors++; $display("FAIL full_second got=%0d/%h exp=2/0000000b", rf_waddr, rf_wdata); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL full_occ1 got=%0d exp=1", occupancy); end
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_fwd();
    rf_grant = 1'b0;
    offer(5'd4, 32'h11);
    step();
    offer(5'd4, 32'h22);
    step();
    exe_valid = 1'b0;
    fwd_raddr = 5'd4;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22)
      begin errors++; $display("FAIL fwd_young got=%b/%h exp=1/00000022", fwd_hit, fwd_data); end
    fwd_raddr = 5'd0;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_x0 got=%b exp=0", fwd_hit); end
    fwd_raddr = 5'd9;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0)
      begin errors++; $display("FAIL fwd_miss got=%b/%h exp=0/00000000", fwd_hit, fwd_data); end
    rf_grant = 1'b1;
    step();
    fwd_raddr = 5'd4;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22)
      begin errors++; $display("FAIL fwd_after_pop got=%b/%h exp=1/00000022", fwd_hit, fwd_data); end
    step();
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_empty got=%b exp=0", fwd_hit); end
  endtask

  task automatic test_x0();
    rf_grant = 1'b0;
    offer(5'd0, 32'h55);
    step();
    exe_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL x0_occ got=%0d exp=1", occupancy); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got=%b exp=0", rf_we); end
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL x0_retire got=%0d exp=0", occupancy); end
  endtask

  task automatic test_back_to_back();
    rf_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) offer(5'(10 + i), 32'(100 + i));
      else exe_valid = 1'b0;
      #1;
      if (i > 0) begin
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'(9 + i) || rf_wdata !== 32'(99 + i) || occupancy !== 2'd1)
          begin errors++; $display("FAIL b2b_%0d got=%b/%0d/%0d/%0d exp=1/%0d/%0d/1", i, rf_we, rf_waddr, rf_wdata, occupancy, 9 + i, 99 + i); end
      end
      step();
    end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_end got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    rf_grant = 1'b0;
    offer(5'd7, 32'h1);
    step();
    offer(5'd8, 32'h2);
    step();
    offer(5'd9, 32'h3);
    flush = 1'b1; rf_grant = 1'b1; fwd_raddr = 5'd8;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_we got=%b exp=0", rf_we); end
    checks++; if (exe_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", exe_ready); end
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h2)
      begin errors++; $display("FAIL flush_fwd got=%b/%h exp=1/00000002", fwd_hit, fwd_data); end
    step();
    flush = 1'b0; exe_valid = 1'b0; rf_grant = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (rf_we !== 1'b0 || fwd_hit !== 1'b0)
      begin errors++; $display("FAIL flush_clear got=%b/%b exp=0/0", rf_we, fwd_hit); end
  endtask

  task automatic test_reset_mid();
    rf_grant = 1'b0;
    offer(5'd12, 32'hDEAD);
    step();
    offer(5'd13, 32'hBEEF);
    step();
    exe_valid = 1'b0; fwd_raddr = 5'd13;
    #1;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rmid_pre got=%0d exp=2", occupancy); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0 || exe_ready !== 1'b0)
      begin errors++; $display("FAIL rmid_ctrl got=%0d/%b/%b exp=0/0/0", occupancy, rf_we, exe_ready); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || fwd_hit !== 1'b0 || fwd_data !== 32'h0)
      begin errors++; $display("FAIL rmid_data got=%0d/%h/%b/%h exp=0/0/0/0", rf_waddr, rf_wdata, fwd_hit, fwd_data); end
    step();
    rstn = 1'b1;
    step();
    checks++; if (occupancy !== 2'd0 || rf_we !== 1'b0)
      begin errors++; $display("FAIL rmid_after got=%0d/%b exp=0/0", occupancy, rf_we); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_slt();
    test_full();
    test_fwd();
    test_x0();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
